// File: rtl/n1_prog_loader.sv
// n1_prog_loader : upstream loader for the n1 core's program RAM.
//
// Takes a byte stream over a valid/ready handshake. The first byte is the
// word count. The words follow as little-endian byte pairs. Each assembled
// word is written into program RAM, starting at address 0. The core is held
// off (cpu_hold) while a load is in flight. Completion and error are
// reported on done/err.
//
// Optional feature macro: N1_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the last word. This byte must equal
//   the XOR of the length byte and all data bytes, otherwise err is set.
//   When undefined, err is only raised by an illegal length byte.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   load_en     level: high requests/continues a load, low aborts or
//               acknowledges done
//   byte_in     stream data
//   byte_valid  byte_in is valid
//   byte_ready  loader can accept a byte (transfer = valid & ready)
//   wr_en       one-cycle program RAM write strobe
//   wr_addr     program RAM write address
//   wr_data     program RAM write data
//   cpu_hold    high while a load is in progress
//   done        load finished (success or error)
//   err         load finished with error, valid while done=1

module n1_prog_loader #(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      LO,
      HI,
      WRITE,
`ifdef N1_LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE
   } state_t;

   localparam logic [7:0] MAX_LEN = 8'(DEPTH);

   state_t            state;
   state_t            state_next;
   logic              err_next;
   logic [7:0]        len;
   logic [ADDR_W-1:0] idx;
   logic [7:0]        lo_byte;
   logic              take;
   logic              last_word;
`ifdef N1_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   // A byte is consumed only while the load is still requested.
   assign take      = byte_valid & byte_ready & load_en;
   assign last_word = (8'(idx) + 8'd1) == len;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and Moore outputs.
   // An abort (load_en low) always wins over a pending handshake.
   // A WRITE cycle still strobes wr_en when it is aborted.
   always_comb begin
      state_next = state;
      err_next   = err;
      byte_ready = 1'b0;
      wr_en      = 1'b0;
      cpu_hold   = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (load_en) state_next = LEN;
         end
         LEN: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (!load_en) begin
               state_next = IDLE;
            end else if (byte_valid) begin
               if (byte_in == 8'd0 || byte_in > MAX_LEN) begin
                  state_next = DONE;
                  err_next   = 1'b1;
               end else begin
                  state_next = LO;
               end
            end
         end
         LO: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (!load_en)        state_next = IDLE;
            else if (byte_valid) state_next = HI;
         end
         HI: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (!load_en)        state_next = IDLE;
            else if (byte_valid) state_next = WRITE;
         end
         WRITE: begin
            wr_en    = 1'b1;
            cpu_hold = 1'b1;
            if (!load_en) begin
               state_next = IDLE;
            end else if (last_word) begin
`ifdef N1_LOADER_CHECKSUM_EN
               state_next = CHK;
`else
               state_next = DONE;
               err_next   = 1'b0;
`endif
            end else begin
               state_next = LO;
            end
         end
`ifdef N1_LOADER_CHECKSUM_EN
         CHK: begin
            byte_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (!load_en) begin
               state_next = IDLE;
            end else if (byte_valid) begin
               state_next = DONE;
               err_next   = (byte_in != csum);
            end
         end
`endif
         DONE: begin
            done = 1'b1;
            if (!load_en) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // done/err are both clear whenever the loader sits in IDLE.
      if (state_next == IDLE) err_next = 1'b0;
   end

   // Datapath: length capture, word assembly, address counter and error flag.
   // The index is left unused after the final write, so it may wrap at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err     <= 1'b0;
         len     <= '0;
         idx     <= '0;
         lo_byte <= '0;
         wr_addr <= '0;
         wr_data <= '0;
`ifdef N1_LOADER_CHECKSUM_EN
         csum    <= '0;
`endif
      end else begin
         err <= err_next;
         case (state)
            LEN: if (take) begin
               len <= byte_in;
               idx <= '0;
`ifdef N1_LOADER_CHECKSUM_EN
               csum <= byte_in;
`endif
            end
            LO: if (take) begin
               lo_byte <= byte_in;
`ifdef N1_LOADER_CHECKSUM_EN
               csum <= csum ^ byte_in;
`endif
            end
            HI: if (take) begin
               wr_data <= {byte_in, lo_byte};
               wr_addr <= idx;
`ifdef N1_LOADER_CHECKSUM_EN
               csum <= csum ^ byte_in;
`endif
            end
            WRITE: idx <= idx + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_n1_prog_loader.sv
// tb_n1_prog_loader : self-checking bench for n1_prog_loader.
//
// Byte streams are driven through the valid/ready handshake with random
// gaps. Every write the DUT issues is captured. The captured writes and the
// final done/err/cpu_hold values are compared against a reference model
// computed directly from the stream contents. The bench follows
// N1_LOADER_CHECKSUM_EN in the same way as the design.

module tb_n1_prog_loader;

   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;
   localparam int WORD_W = 16;

   typedef logic [7:0] byteQ_t[$];

   logic              clk = 1'b0;
   logic              rst;
   logic              load_en;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic              cpu_hold;
   logic              done;
   logic              err;

   int total = 0;
   int bad   = 0;

   logic [ADDR_W+WORD_W-1:0] writeQ[$];

   n1_prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_en    (load_en),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err)
   );

   // 10 time-unit clock.
   always #5 clk = ~clk;

   // Capture every write strobe away from the active edge.
   always @(negedge clk) begin
      if (wr_en) writeQ.push_back({wr_addr, wr_data});
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one byte and hold it until it is accepted.
   // The task is entered and left at a falling edge.
   task automatic sendByte(input logic [7:0] b, input int gapMax);
      int n;
      int gap;
      gap = $urandom_range(0, gapMax);
      if (gap > 0) begin
         byte_valid = 1'b0;
         byte_in    = 8'($urandom);
         repeat (gap) @(negedge clk);
      end
      byte_in    = b;
      byte_valid = 1'b1;
      n = 0;
      while (!byte_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) checkOutput("handshake_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   // Drive one load. When abortAfter is negative the full stream is sent.
   // Otherwise the length byte plus abortAfter data bytes are sent, and then
   // load_en is dropped.
   task automatic applyStimulus(input string name, input byteQ_t s, input int abortAfter, input int gapMax);
      int len, nSend, expWrites, n;
      bit lenBad, expErr;
      logic [7:0] x;
      logic [ADDR_W+WORD_W-1:0] expW;

      // Reference model: legal length, expected writes and expected error.
      len    = int'(s[0]);
      lenBad = (len == 0 || len > DEPTH);
      x      = 8'h00;
      expErr = lenBad;
      if (!lenBad) begin
         for (int i = 0; i <= 2*len; i++) x = x ^ s[i];
`ifdef N1_LOADER_CHECKSUM_EN
         expErr = (s[2*len+1] != x);
`endif
      end
      nSend     = (abortAfter < 0) ? s.size() : abortAfter + 1;
      expWrites = lenBad ? 0 : ((abortAfter < 0) ? len : abortAfter / 2);

      writeQ.delete();
      load_en = 1'b1;
      @(negedge clk);
      checkOutput({name, "_len_ready"}, 32'(byte_ready), 32'd1);
      checkOutput({name, "_len_hold"}, 32'(cpu_hold), 32'd1);

      for (int i = 0; i < nSend; i++) begin
         sendByte(s[i], (i == 0) ? 0 : gapMax);
         if (i == 0 && lenBad) begin
            checkOutput({name, "_badlen_done"}, 32'(done), 32'd1);
            checkOutput({name, "_badlen_err"}, 32'(err), 32'd1);
         end
      end
      byte_valid = 1'b0;

      if (abortAfter >= 0) begin
         load_en = 1'b0;
         @(negedge clk);
         checkOutput({name, "_abort_done"}, 32'(done), 32'd0);
         checkOutput({name, "_abort_hold"}, 32'(cpu_hold), 32'd0);
         checkOutput({name, "_abort_ready"}, 32'(byte_ready), 32'd0);
         repeat (3) @(negedge clk);
      end else begin
         n = 0;
         while (!done && n < 20) begin
            @(negedge clk);
            n++;
         end
         checkOutput({name, "_done"}, 32'(done), 32'd1);
         checkOutput({name, "_err"}, 32'(err), 32'(expErr));
         checkOutput({name, "_hold_released"}, 32'(cpu_hold), 32'd0);
         repeat (2) @(negedge clk);
         checkOutput({name, "_done_held"}, 32'(done), 32'd1);
         load_en = 1'b0;
         @(negedge clk);
         checkOutput({name, "_idle_done"}, 32'(done), 32'd0);
         checkOutput({name, "_idle_err"}, 32'(err), 32'd0);
      end

      checkOutput({name, "_write_count"}, 32'(writeQ.size()), 32'(expWrites));
      for (int k = 0; k < expWrites && k < writeQ.size(); k++) begin
         expW = {ADDR_W'(k), s[2*k+2], s[2*k+1]};
         checkOutput({name, "_write"}, 32'(writeQ[k]), 32'(expW));
      end
   endtask

   // Build a legal stream of len words, with an optional checksum byte.
   function automatic byteQ_t makeStream(input int len, input bit corrupt);
      byteQ_t s;
      logic [7:0] x;
      s.push_back(8'(len));
      x = 8'(len);
      for (int i = 0; i < 2*len; i++) begin
         s.push_back(8'($urandom));
         x = x ^ s[i+1];
      end
`ifdef N1_LOADER_CHECKSUM_EN
      s.push_back(corrupt ? ~x : x);
`else
      if (corrupt) x = ~x;
`endif
      return s;
   endfunction

   initial begin
      byteQ_t s;
      logic [31:0] outs;
      int len, abortAt;

      rst        = 1'b1;
      load_en    = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      #12;
      outs = {byte_ready, wr_en, cpu_hold, done, err, 11'd0, wr_data};
      checkOutput("reset_outputs", outs, 32'd0);
      checkOutput("reset_addr", 32'(wr_addr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("idle_ready", 32'(byte_ready), 32'd0);
      checkOutput("idle_hold", 32'(cpu_hold), 32'd0);

      // Basic two-word load. The byte held during WRITE is accepted next.
      s = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
`ifdef N1_LOADER_CHECKSUM_EN
      s.push_back(8'h42);
`endif
      applyStimulus("basic", s, -1, 0);

      // Illegal lengths.
      s = '{8'h00};
      applyStimulus("len0", s, -1, 0);
      s = '{8'h21};
      applyStimulus("len33", s, -1, 0);

      // One word with valid gaps.
      s = makeStream(1, 1'b0);
      applyStimulus("gaps", s, -1, 2);

      // Full-depth load, word k = k*0x0101.
      s = '{8'h20};
      for (int k = 0; k < DEPTH; k++) begin
         s.push_back(8'(k));
         s.push_back(8'(k));
      end
`ifdef N1_LOADER_CHECKSUM_EN
      s.push_back(8'h20);
`endif
      applyStimulus("full", s, -1, 0);

      // Abort after the third word's low byte, then start a fresh load.
      s = makeStream(4, 1'b0);
      applyStimulus("abort", s, 5, 0);
      s = makeStream(2, 1'b0);
      applyStimulus("after_abort", s, -1, 0);

      // Asynchronous reset while in HI, between clock edges.
      writeQ.delete();
      load_en = 1'b1;
      @(negedge clk);
      s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 6; i++) sendByte(s[i], 0);
      byte_valid = 1'b0;
      checkOutput("rst_pre_writes", 32'(writeQ.size()), 32'd2);
      #2 rst = 1'b1;
      #1;
      outs = {byte_ready, wr_en, cpu_hold, done, err, 11'd0, wr_data};
      checkOutput("async_rst_outputs", outs, 32'd0);
      checkOutput("async_rst_addr", 32'(wr_addr), 32'd0);
      load_en = 1'b0;
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_hold", 32'(cpu_hold), 32'd0);
      checkOutput("post_rst_ready", 32'(byte_ready), 32'd0);

`ifdef N1_LOADER_CHECKSUM_EN
      s = '{8'h01, 8'h34, 8'h12, 8'h27};
      applyStimulus("chk_good", s, -1, 0);
      s = '{8'h01, 8'h34, 8'h12, 8'h00};
      applyStimulus("chk_bad", s, -1, 0);
`endif

      // Randomized loads, including bad lengths, aborts and gaps.
      for (int it = 0; it < 24; it++) begin
         if ($urandom_range(0, 7) == 0) begin
            s.delete();
            s.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255)));
            applyStimulus("rand_badlen", s, -1, 0);
         end else begin
            len = $urandom_range(1, DEPTH);
            s   = makeStream(len, $urandom_range(0, 3) == 0);
            abortAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2*len-1) : -1;
            applyStimulus("rand", s, abortAt, $urandom_range(0, 2));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/n1_prog_loader.md
Name: n1_prog_loader

Overview:
- Upstream loader for the n1 core's 32 x 16-bit program RAM.
- Accepts a byte stream over a valid/ready handshake: length header, then little-endian 16-bit instruction words.
- Issues one write per assembled word into program RAM, starting at address 0.
- Holds the core (cpu_hold) while loading and flags completion or error.

Parameters:
- DEPTH, 32, number of program RAM words; maximum accepted length.
- ADDR_W, 5, program RAM address width (must satisfy 2^ADDR_W >= DEPTH).
- WORD_W, 16, instruction width; fixed at 2 bytes, low byte first.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_en  input  1  level; high requests or continues a load, low aborts or acknowledges done.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader can accept byte; transfer occurs when byte_valid & byte_ready.
- wr_en  output  1  one-cycle program RAM write strobe.
- wr_addr  output  ADDR_W  program RAM write address.
- wr_data  output  WORD_W  program RAM write data.
- cpu_hold  output  1  high while a load is in progress; core must not fetch.
- done  output  1  load finished (success or error).
- err  output  1  load finished with error; valid when done=1.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - All outputs 0; wr_addr=0, wr_data=0.
  - Internal word count, length and low-byte register cleared.
- States: IDLE, LEN, LO, HI, WRITE, (CHK), DONE.
- byte_ready=1 only in LEN, LO, HI (and CHK); 0 in IDLE, WRITE, DONE.
- IDLE:
  - load_en=1 -> LEN next cycle; cpu_hold=1 from that cycle.
  - done and err are 0 in IDLE.
- LEN, on handshake:
  - len = byte_in.
  - len=0 or len>DEPTH -> DONE with err=1; no writes.
  - Otherwise -> LO; word index=0.
- LO, on handshake: latch low byte -> HI.
- HI, on handshake:
  - wr_data <= {byte_in, low byte}; wr_addr <= word index.
  - -> WRITE.
- WRITE (exactly one cycle):
  - wr_en=1; byte_ready=0.
  - wr_en rises the cycle after the HI handshake.
  - Word index increments.
  - If index+1 == len -> DONE (or CHK when CHECKSUM_EN is defined); else -> LO.
- DONE:
  - done=1, cpu_hold=0.
  - Held while load_en=1; load_en=0 -> IDLE.
  - done/err clear on IDLE entry.
- Abort: load_en=0 in LEN/LO/HI/CHK -> IDLE next cycle.
  - No further writes; done stays 0; cpu_hold drops.
  - Words already written stay in RAM.
- Abort and WRITE in the same cycle: the WRITE strobe completes; next state is IDLE.
- byte_valid gaps: state holds indefinitely; no timeout.
- Bytes presented while byte_ready=0 are not consumed; the source must hold them.
- wr_addr: never exceeds len-1. For len=DEPTH the final write is at DEPTH-1; the index is not used after that.
- wr_en is never asserted outside WRITE.

Optional Feature:
- Macro: N1_LOADER_CHECKSUM_EN.
- Defined:
  - Running XOR of the length byte and all data bytes.
  - After the final WRITE, state CHK accepts one more byte.
  - Byte equal to the running XOR -> DONE err=0; unequal -> DONE err=1.
  - Words are already written; err only signals that the core must not be released.
- Not defined:
  - No CHK state; final WRITE -> DONE with err=0.
  - err is set only by a bad length.

Test Plan:
- Basic 2-word load:
  - Stimulus: load_en=1; bytes 02,34,12,CD,AB (plus checksum 42 when the macro is enabled).
  - Response: wr_en pulses (addr0,0x1234) then (addr1,0xABCD); done=1, err=0, cpu_hold=0.
- Bad length:
  - Stimulus: length byte 00, and separately 21 (33).
  - Response: no wr_en; done=1, err=1 one cycle after the handshake.
- Backpressure and gaps:
  - Stimulus: 1-word load with byte_valid toggling 1/0.
  - Response: byte_ready=0 during WRITE; the byte held during WRITE is consumed the next cycle; exactly one write of the correct word.
- Full-depth load:
  - Stimulus: len=32 (0x20), word k = k*0x0101.
  - Response: 32 writes, addresses 0..31 in order; no write beyond 31; done=1.
- Abort mid-load:
  - Stimulus: deassert load_en after the 3rd word's low byte.
  - Response: 2 writes only; IDLE next cycle; done=0, cpu_hold=0.
  - Reasserting load_en starts a fresh load at address 0.
- Async reset in HI:
  - Stimulus: rst pulse between clock edges.
  - Response: all outputs 0 immediately, without waiting for a clock edge; state IDLE.
- Checksum (N1_LOADER_CHECKSUM_EN):
  - Stimulus: 1-word load 01,34,12 with checksum 0x27 (01^34^12).
  - Response: err=0.
  - With checksum 0x00: err=1, write still performed.
